// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register with operand bypass and load-use stall (bypass/refresh enabled by ID_EX_FWD_EN)
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rd1,
  input  logic [31:0] in_rd2,
  input  logic [15:0] in_ctrl,
  input  logic        in_we,
  input  logic        in_is_load,
  input  logic        exm_we,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [15:0] out_ctrl,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_is_load,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_a,
  output logic [31:0] out_b
);
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic        we_q, we_d, load_q, load_d;
  logic        hazard, in_fire, out_fire, ref_a, ref_b;

  assign out_fire = valid_q & out_ready;
  assign in_ready = (~valid_q | out_ready) & ~hazard;
  assign in_fire  = in_valid & in_ready;

`ifdef ID_EX_FWD_EN
  logic exm_a, exm_b, wb_a, wb_b;
  assign hazard = in_valid & valid_q & load_q & we_q & (rd_q != 5'd0) & ((in_rs1 == rd_q) | (in_rs2 == rd_q));
  assign exm_a  = exm_we & (exm_rd != 5'd0) & (exm_rd == rs1_q);
  assign exm_b  = exm_we & (exm_rd != 5'd0) & (exm_rd == rs2_q);
  assign wb_a   = wb_we & (wb_rd != 5'd0) & (wb_rd == rs1_q);
  assign wb_b   = wb_we & (wb_rd != 5'd0) & (wb_rd == rs2_q);
  assign out_a  = exm_a ? exm_data : wb_a ? wb_data : a_q;
  assign out_b  = exm_b ? exm_data : wb_b ? wb_data : b_q;
  // a stalled entry picks up late write-backs so they are not lost when wb moves on
  assign ref_a  = valid_q & ~out_fire & ~flush & wb_a;
  assign ref_b  = valid_q & ~out_fire & ~flush & wb_b;
`else
  logic haz1, haz2, unused_fwd;
  assign haz1   = (in_rs1 != 5'd0) & ((valid_q & we_q & (in_rs1 == rd_q)) | (exm_we & (in_rs1 == exm_rd)));
  assign haz2   = (in_rs2 != 5'd0) & ((valid_q & we_q & (in_rs2 == rd_q)) | (exm_we & (in_rs2 == exm_rd)));
  assign hazard = in_valid & (haz1 | haz2);
  assign out_a  = a_q;
  assign out_b  = b_q;
  assign ref_a  = 1'b0;
  assign ref_b  = 1'b0;
  assign unused_fwd = ^{exm_data, wb_we, wb_rd};
`endif

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_imm     = imm_q;
  assign out_ctrl    = ctrl_q;
  assign out_rd      = rd_q;
  assign out_we      = we_q;
  assign out_is_load = load_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;

  // next-state: flush beats capture, capture beats drain, otherwise hold
  always_comb begin
    valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;
    pc_d    = in_fire ? in_pc : pc_q;
    imm_d   = in_fire ? in_imm : imm_q;
    ctrl_d  = in_fire ? in_ctrl : ctrl_q;
    rs1_d   = in_fire ? in_rs1 : rs1_q;
    rs2_d   = in_fire ? in_rs2 : rs2_q;
    rd_d    = in_fire ? in_rd : rd_q;
    we_d    = in_fire ? in_we : we_q;
    load_d  = in_fire ? in_is_load : load_q;
    a_d     = in_fire ? in_rd1 : ref_a ? wb_data : a_q;
    b_d     = in_fire ? in_rd2 : ref_b ? wb_data : b_q;
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      load_q  <= load_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (expectations adapt to ID_EX_FWD_EN)
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_we, in_is_load, exm_we, wb_we, flush;
  logic        out_valid, out_ready, out_we, out_is_load;
  logic [31:0] in_pc, in_imm, in_rd1, in_rd2, exm_data, wb_data;
  logic [31:0] out_pc, out_imm, out_a, out_b;
  logic [4:0]  in_rs1, in_rs2, in_rd, exm_rd, wb_rd, out_rd, out_rs1, out_rs2;
  logic [15:0] in_ctrl, out_ctrl;
  int vectors = 0;
  int miscompares = 0;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_ctrl(in_ctrl), .in_we(in_we), .in_is_load(in_is_load),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_we(out_we), .out_is_load(out_is_load),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_a(out_a), .out_b(out_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic we, input logic ld);
    in_valid = 1'b1; in_pc = pc; in_imm = pc + 32'h8; in_ctrl = pc[15:0] ^ 16'hBEEF;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd1 = d1; in_rd2 = d2; in_we = we; in_is_load = ld;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    exm_we = 1'b0; exm_rd = '0; exm_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(32'hDEAD_0000, 5'd0, 5'd0, 5'd1, 32'h99, 32'h98, 1'b1, 1'b0);
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    settle();
    chk("rel_ready", {31'd0, in_ready}, 32'd1);
    drive(32'h100, 5'd5, 5'd6, 5'd9, 32'h11, 32'h22, 1'b1, 1'b0);
    settle();
    chk("cap_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("cap_valid", {31'd0, out_valid}, 32'd1);
    chk("cap_pc", out_pc, 32'h100);
    chk("cap_imm", out_imm, 32'h108);
    chk("cap_ctrl", {16'd0, out_ctrl}, 32'h0000_BFEF);
    chk("cap_rd", {27'd0, out_rd}, 32'd9);
    chk("cap_rs1", {27'd0, out_rs1}, 32'd5);
    chk("cap_a", out_a, 32'h11);
    chk("cap_b", out_b, 32'h22);
    exm_we = 1'b1; exm_rd = 5'd5; exm_data = 32'hAA; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBB;
    settle();
    chk("byp_exm", out_a, FWD ? 32'hAA : 32'h11);
    chk("byp_b_untouched", out_b, 32'h22);
    exm_we = 1'b0;
    settle();
    chk("byp_wb", out_a, FWD ? 32'hBB : 32'h11);
    chk("held_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_we = 1'b0;
    settle();
    chk("refresh_a", out_a, FWD ? 32'hBB : 32'h11);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    drive(32'h180, 5'd9, 5'd0, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("alu_dep_ready", {31'd0, in_ready}, FWD ? 32'd1 : 32'd0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    drive(32'h200, 5'd1, 5'd2, 5'd3, 32'h33, 32'h44, 1'b1, 1'b1);
    tick();
    chk("ld_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_is_load", {31'd0, out_is_load}, 32'd1);
    drive(32'h300, 5'd0, 5'd3, 5'd4, 32'h55, 32'h66, 1'b1, 1'b0);
    settle();
    chk("lu_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_cap_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_cap_pc", out_pc, 32'h300);
    chk("lu_cap_b", out_b, 32'h66);
    drive(32'h400, 5'd0, 5'd0, 5'd0, 32'h77, 32'h78, 1'b0, 1'b0);
    settle();
    chk("rep_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rep_valid", {31'd0, out_valid}, 32'd1);
    chk("rep_pc", out_pc, 32'h400);
    out_ready = 1'b0;
    exm_we = 1'b1; exm_rd = 5'd0; exm_data = 32'hFF; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hEE;
    settle();
    chk("rd0_a", out_a, 32'h77);
    tick();
    chk("rd0_norefresh", out_a, 32'h77);
    wb_we = 1'b0; exm_we = 1'b0;
    out_ready = 1'b1;
    drive(32'h500, 5'd0, 5'd0, 5'd7, 32'h1, 32'h2, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    drive(32'h600, 5'd4, 5'd0, 5'd8, 32'h1, 32'h2, 1'b1, 1'b0);
    exm_we = 1'b1; exm_rd = 5'd4; exm_data = 32'h5;
    settle();
    chk("exm_haz_ready", {31'd0, in_ready}, FWD ? 32'd1 : 32'd0);
    in_rs1 = 5'd0; exm_rd = 5'd0;
    settle();
    chk("exm_rs0_ready", {31'd0, in_ready}, 32'd1);
    exm_we = 1'b0;
    drive(32'h700, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0; flush = 1'b1;
    drive(32'h800, 5'd0, 5'd0, 5'd3, 32'hB1, 32'hB2, 1'b1, 1'b0);
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_a", out_a, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
